// File: rtl/bounce_gen.sv
// Bouncy-switch source: turns a clean level-change request into an LFSR-driven contact-bounce
// burst on b, then holds b at the target. Define BOUNCE_GEN_FIXED_GAP_EN for a fixed gap of 2^GAP_W.
module bounce_gen #(
  parameter int         BOUNCE_EDGES  = 4,
  parameter int         GAP_W         = 2,
  parameter int         SETTLE_CYCLES = 8,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic level_req,
  output logic b,
  output logic busy,
  output logic done
);

  localparam int N_TOG = 2*BOUNCE_EDGES + 1;
  localparam int TW    = $clog2(2*BOUNCE_EDGES + 2);
  localparam int GW    = GAP_W + 1;
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_SETTLE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_b, w_b_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [7:0]      r_lfsr, w_lfsr_nxt;
  logic [TW-1:0]   r_toggle_cnt, w_toggle_cnt_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [SW-1:0]   r_settle_cnt, w_settle_cnt_nxt;
  logic [GW-1:0]   w_gap;

  // x^8+x^6+x^5+x^4+1, Fibonacci form
  assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

`ifdef BOUNCE_GEN_FIXED_GAP_EN
  assign w_gap = GW'(1) << GAP_W;
`else
  assign w_gap = {1'b0, r_lfsr[GAP_W-1:0]} + GW'(1);
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_b_nxt          = r_b;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_toggle_cnt_nxt = r_toggle_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (level_req == r_b) begin
            w_done_nxt = 1'b1;
          end else begin
            w_b_nxt          = ~r_b;
            w_busy_nxt       = 1'b1;
            w_toggle_cnt_nxt = TW'(1);
            w_gap_cnt_nxt    = w_gap;
            if (N_TOG == 1) begin
              w_state_nxt      = S_SETTLE;
              w_settle_cnt_nxt = SW'(SETTLE_CYCLES);
            end else begin
              w_state_nxt = S_BOUNCE;
            end
          end
        end
      end
      S_BOUNCE: begin
        if (r_gap_cnt == GW'(1)) begin
          w_b_nxt          = ~r_b;
          w_toggle_cnt_nxt = r_toggle_cnt + TW'(1);
          w_gap_cnt_nxt    = w_gap;
          // odd toggle count means b now equals the captured target
          if (r_toggle_cnt + TW'(1) == TW'(N_TOG)) begin
            w_state_nxt      = S_SETTLE;
            w_settle_cnt_nxt = SW'(SETTLE_CYCLES);
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GW'(1);
        end
      end
      S_SETTLE: begin
        w_settle_cnt_nxt = r_settle_cnt - SW'(1);
        if (r_settle_cnt == SW'(1)) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lfsr       <= LFSR_SEED;
      r_toggle_cnt <= '0;
      r_gap_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_b          <= w_b_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_toggle_cnt <= w_toggle_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
    end
  end

  assign b    = r_b;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Synthesizable bouncy-switch source: converts a clean level-change command into a contact-bounce waveform on `b`, then settles at the commanded level.
- Drives the bouncy-input side of the pushbutton/switch debouncer for on-board self-test and bench stimulus.
- Bounce pattern comes from an internal LFSR, so successive presses differ.
- Handshake: `start`/`busy`/`done`.

Parameters:
- BOUNCE_EDGES, 4, glitch pairs per transition. Total toggles per transition = 2*BOUNCE_EDGES+1.
- GAP_W, 2, width of the random gap field. Gap between toggles is 1..2^GAP_W cycles.
- SETTLE_CYCLES, 8, cycles `b` is held stable at the target before `done` (>=1).
- LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to move `b` to `level_req`
- level_req  input  1  target settled level, sampled when `start` is accepted
- b  output  1  bouncy output (registered)
- busy  output  1  high from acceptance until the `done` edge
- done  output  1  one-cycle pulse when `b` has settled

Behaviour:
- Reset values (on posedge `clk` with `rst`=1):
  - b=0, busy=0, done=0, state=IDLE, all counters 0, lfsr=LFSR_SEED.
  - Reset mid-operation aborts immediately with the same values.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every cycle when not in reset.
  - Gap value G = lfsr[GAP_W-1:0] + 1, sampled at each toggle edge.
- States:
  - IDLE:
    - `done` defaults low every cycle unless asserted below.
    - `start`=1 and `level_req`==b: no bounce, stay IDLE, done=1 on that edge, busy stays 0.
    - `start`=1 and `level_req`!=b: capture target; on the same edge toggle b (toggle #1), busy=1, toggle_cnt=1, gap_cnt=G. Then go to BOUNCE, or to SETTLE if 2*BOUNCE_EDGES+1==1.
  - BOUNCE:
    - gap_cnt decrements each cycle.
    - On the edge where gap_cnt==1: toggle b, toggle_cnt+1, reload gap_cnt=G.
    - When toggle_cnt reaches 2*BOUNCE_EDGES+1: go to SETTLE, settle_cnt=SETTLE_CYCLES. The odd toggle count guarantees b==target.
  - SETTLE:
    - b held constant; settle_cnt decrements.
    - On the edge where settle_cnt==1: done=1, busy=0, go to IDLE.
- Simultaneous events:
  - `start` while busy=1: ignored, no queueing.
  - `start` on the same edge `done` pulses (state still SETTLE): ignored.
  - `level_req` is sampled only at acceptance.
- Latency: with toggle edges at offsets t1=0, t2, ..., tN (N=2*BOUNCE_EDGES+1), `done` asserts at edge tN+SETTLE_CYCLES after acceptance.
- Widths:
  - toggle_cnt: $clog2(2*BOUNCE_EDGES+2) bits.
  - gap_cnt: GAP_W+1 bits.
  - settle_cnt: $clog2(SETTLE_CYCLES+1) bits.
  - No wrap is permitted in any counter.

Optional Feature:
- Macro: BOUNCE_GEN_FIXED_GAP_EN.
- Defined: G is fixed at 2^GAP_W for every gap. The waveform is fully deterministic; the LFSR still runs but does not affect `b`.
- Undefined: G comes from the LFSR as above.

Test Plan:
- FIXED_GAP_EN defined, defaults, b=0, start=1 with level_req=1 at edge 0:
  - b toggles at edges 0,4,8,...,32 (9 toggles); b=1 after edge 32.
  - done=1 at edge 40 only; busy high for edges 0..39.
- Same, then level_req=0 press: mirror waveform; b ends at 0; exactly 9 toggles counted on b.
- b=1 idle, start=1 with level_req=1: done=1 the next edge, busy never rises, b unchanged.
- start pulses at edges 5 and 20 during a press: no change to toggle count or done timing versus the first scenario.
- rst=1 at edge 15 mid-bounce: b=0, busy=0, done=0 next edge. A fresh start afterwards produces the full 9-toggle sequence.
- Random-gap build, BOUNCE_EDGES=0:
  - single toggle, done at edge SETTLE_CYCLES.
  - With BOUNCE_EDGES=4, every inter-toggle gap is within 1..4 cycles and final b equals level_req across 50 random presses.
